// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and widths for the register-unit write side
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_DMEM = 2'b01,
        WB_PC4  = 2'b10
    } wb_src_e;

endpackage

// File: rtl/ru_scoreboard.sv
// rtl/ru_scoreboard.sv - per-register pending-write counters with hazard query
module ru_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_req,
    input  logic       inc_en,
    input  logic [4:0] inc_rd,
    input  logic       dec_en,
    input  logic [4:0] dec_rd,
    input  logic       byp_en,
    input  logic [4:0] byp_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       haz1,
    output logic       haz2,
    output logic       byp1,
    output logic       byp2,
    output logic       sat
);
    import riscv_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [CNT_W-1:0] c1, c2, c_inc;
    logic             up, dn;

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            up = inc_en && (inc_rd == 5'(i));
            dn = dec_en && (dec_rd == 5'(i));
            // Guards keep a broken pipeline from ever wrapping a counter.
            if (up && !dn && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dn && !up && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        c1    = (rs1 == '0)    ? '0 : cnt_q[rs1];
        c2    = (rs2 == '0)    ? '0 : cnt_q[rs2];
        c_inc = (inc_rd == '0) ? '0 : cnt_q[inc_rd];
        byp1  = (c1 == CNT_ONE) && byp_en && (byp_rd == rs1);
        byp2  = (c2 == CNT_ONE) && byp_en && (byp_rd == rs2);
        haz1  = (c1 != '0) && !byp1;
        haz2  = (c2 != '0) && !byp2;
        // A retire of the same register this cycle frees the slot the issue needs.
        sat   = inc_req && (c_inc == CNT_MAX) && !(dec_en && (dec_rd == inc_rd));
    end

endmodule

// File: rtl/ru_wb_ctrl.sv
// rtl/ru_wb_ctrl.sv - WB stage register, write-back mux, ru write port, RAW stall and bypass
module ru_wb_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_issue,
    input  logic            id_RUwrite,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] RU1,
    input  logic [XLEN-1:0] RU2,
    input  logic            mem_valid,
    input  logic            mem_tracked,
    input  logic            mem_kill,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_RUdataWrSrc,
    input  logic [XLEN-1:0] mem_alu_res,
    input  logic [XLEN-1:0] mem_dm_rd,
    input  logic [XLEN-1:0] mem_pc_inc,
    output logic            RUwrite,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] RUdw,
    output logic            id_stall,
    output logic [XLEN-1:0] id_RU1,
    output logic [XLEN-1:0] id_RU2
);
    import riscv_pkg::*;

    logic            wb_valid_q, wb_valid_d;
    logic            wb_tracked_q, wb_tracked_d;
    logic            wb_kill_q, wb_kill_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic retire, inc_req, inc_en;
    logic haz1, haz2, byp1, byp2, sat;

    always_comb begin
        wb_valid_d   = mem_valid;
        wb_tracked_d = mem_valid & mem_tracked;
        wb_kill_d    = mem_kill;
        wb_rd_d      = mem_rd;
        case (wb_src_e'(mem_RUdataWrSrc))
            WB_DMEM: wb_data_d = mem_dm_rd;
            WB_PC4:  wb_data_d = mem_pc_inc;
            default: wb_data_d = mem_alu_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_tracked_q <= 1'b0;
            wb_kill_q    <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_tracked_q <= wb_tracked_d;
            wb_kill_q    <= wb_kill_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Killed instructions still retire so their pending count is released.
    assign retire  = wb_valid_q & wb_tracked_q;
    assign RUwrite = retire & ~wb_kill_q;
    assign rd      = wb_rd_q;
    assign RUdw    = wb_data_q;

    assign inc_req  = id_issue & id_RUwrite & (id_rd != '0);
    assign id_stall = haz1 | haz2 | sat;
    assign inc_en   = inc_req & ~id_stall;

    ru_scoreboard #(
        .CNT_W (CNT_W)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_req (inc_req),
        .inc_en  (inc_en),
        .inc_rd  (id_rd),
        .dec_en  (retire),
        .dec_rd  (wb_rd_q),
        .byp_en  (RUwrite),
        .byp_rd  (wb_rd_q),
        .rs1     (rs1),
        .rs2     (rs2),
        .haz1    (haz1),
        .haz2    (haz2),
        .byp1    (byp1),
        .byp2    (byp2),
        .sat     (sat)
    );

    assign id_RU1 = byp1 ? wb_data_q : RU1;
    assign id_RU2 = byp2 ? wb_data_q : RU2;

endmodule

// File: tb/tb_ru_wb_ctrl.sv
// tb/tb_ru_wb_ctrl.sv - directed and randomized self-checking bench for ru_wb_ctrl
module tb_ru_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_issue, id_RUwrite;
    logic [4:0]  id_rd, rs1, rs2, mem_rd;
    logic [31:0] RU1, RU2, mem_alu_res, mem_dm_rd, mem_pc_inc;
    logic        mem_valid, mem_tracked, mem_kill;
    logic [1:0]  mem_RUdataWrSrc;
    logic        RUwrite, id_stall;
    logic [4:0]  rd;
    logic [31:0] RUdw, id_RU1, id_RU2;

    int tests = 0;
    int failed = 0;

    int          m_cnt [32];
    bit          m_wv, m_wt, m_wk;
    logic [4:0]  m_wrd;
    logic [31:0] m_wd;
    int          q [$];

    always #5 clk = ~clk;

    ru_wb_ctrl #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_issue(id_issue), .id_RUwrite(id_RUwrite), .id_rd(id_rd),
        .rs1(rs1), .rs2(rs2), .RU1(RU1), .RU2(RU2),
        .mem_valid(mem_valid), .mem_tracked(mem_tracked), .mem_kill(mem_kill),
        .mem_rd(mem_rd), .mem_RUdataWrSrc(mem_RUdataWrSrc),
        .mem_alu_res(mem_alu_res), .mem_dm_rd(mem_dm_rd), .mem_pc_inc(mem_pc_inc),
        .RUwrite(RUwrite), .rd(rd), .RUdw(RUdw),
        .id_stall(id_stall), .id_RU1(id_RU1), .id_RU2(id_RU2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_wv = 0; m_wt = 0; m_wk = 0; m_wrd = '0; m_wd = '0;
        q.delete();
    endtask

    task automatic idle();
        id_issue = 0; id_RUwrite = 0; id_rd = '0; rs1 = '0; rs2 = '0;
        RU1 = $urandom; RU2 = $urandom;
        mem_valid = 0; mem_tracked = 0; mem_kill = 0; mem_rd = '0; mem_RUdataWrSrc = '0;
        mem_alu_res = $urandom; mem_dm_rd = $urandom; mem_pc_inc = $urandom;
    endtask

    task automatic deliver(input logic [4:0] r, input logic [1:0] src, input bit kill);
        mem_valid = 1; mem_tracked = 1; mem_kill = kill; mem_rd = r; mem_RUdataWrSrc = src;
    endtask

    task automatic issue(input logic [4:0] r);
        id_issue = 1; id_RUwrite = 1; id_rd = r;
    endtask

    // Operand whose only pending writer is leaving WB with a real write is forwarded.
    function automatic bit f_byp(input logic [4:0] rs, input bit wr);
        return rs != 0 && m_cnt[rs] == 1 && wr && m_wrd == rs;
    endfunction

    function automatic bit f_haz(input logic [4:0] rs, input bit wr);
        return rs != 0 && m_cnt[rs] > 0 && !f_byp(rs, wr);
    endfunction

    task automatic cycle();
        bit e_wr, e_ret, e_sat, e_stall, acc;
        logic [4:0] ird;
        #1;
        e_wr  = m_wv && m_wt && !m_wk;
        e_ret = m_wv && m_wt;
        e_sat = id_issue && id_RUwrite && id_rd != 0 && m_cnt[id_rd] == 3
                && !(e_ret && m_wrd == id_rd);
        e_stall = f_haz(rs1, e_wr) || f_haz(rs2, e_wr) || e_sat;
        chk("m_RUwrite", 32'(RUwrite), 32'(e_wr));
        chk("m_rd", 32'(rd), 32'(m_wrd));
        chk("m_RUdw", RUdw, m_wd);
        chk("m_stall", 32'(id_stall), 32'(e_stall));
        chk("m_RU1", id_RU1, f_byp(rs1, e_wr) ? m_wd : RU1);
        chk("m_RU2", id_RU2, f_byp(rs2, e_wr) ? m_wd : RU2);
        acc = id_issue && !e_stall && id_RUwrite && id_rd != 0;
        ird = id_rd;
        if (mem_valid && mem_tracked && q.size() > 0) void'(q.pop_front());
        @(posedge clk);
        if (e_ret) m_cnt[m_wrd] = m_cnt[m_wrd] - 1;
        if (acc) begin
            m_cnt[ird] = m_cnt[ird] + 1;
            q.push_back(int'(ird));
        end
        m_wv = mem_valid; m_wt = mem_valid && mem_tracked; m_wk = mem_kill; m_wrd = mem_rd;
        m_wd = (mem_RUdataWrSrc == 2'b01) ? mem_dm_rd :
               (mem_RUdataWrSrc == 2'b10) ? mem_pc_inc : mem_alu_res;
        #1;
    endtask

    task automatic rand_cycle();
        idle();
        rs1 = 5'($urandom_range(0, 4)); rs2 = 5'($urandom_range(0, 4));
        id_issue = 1'($urandom); id_RUwrite = 1'($urandom); id_rd = 5'($urandom_range(0, 4));
        mem_RUdataWrSrc = 2'($urandom);
        if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            deliver(5'(q[0]), mem_RUdataWrSrc, $urandom_range(0, 3) == 0);
        end else begin
            mem_valid = 1'($urandom); mem_kill = 1'($urandom); mem_rd = 5'($urandom);
        end
        cycle();
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 0;
        deliver(5'd3, 2'b01, 0);
        @(posedge clk); #1;
        chk("rst_RUwrite", 32'(RUwrite), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_RUdw", RUdw, 0);
        chk("rst_stall", 32'(id_stall), 0);
        idle();
        rst_n = 1;

        issue(5'd21);
        cycle();
        idle(); issue(5'd18); rs1 = 5'd21;
        deliver(5'd21, 2'b01, 0); mem_dm_rd = 32'hAAAAAA95;
        #1; chk("raw_stall", 32'(id_stall), 1);
        cycle();
        idle(); rs1 = 5'd21;
        deliver(5'd18, 2'b10, 0); mem_pc_inc = 32'hF565FA95;
        #1;
        chk("wb_dm_wr", 32'(RUwrite), 1);
        chk("wb_dm_rd", 32'(rd), 21);
        chk("wb_dm_data", RUdw, 32'hAAAAAA95);
        chk("raw_retire_stall", 32'(id_stall), 0);
        chk("raw_bypass", id_RU1, 32'hAAAAAA95);
        cycle();
        idle(); rs1 = 5'd21; RU1 = 32'h1234_5678;
        #1;
        chk("wb_pc_rd", 32'(rd), 18);
        chk("wb_pc_data", RUdw, 32'hF565FA95);
        chk("raw_after", id_RU1, 32'h1234_5678);
        cycle();

        idle(); issue(5'd5);
        cycle();
        idle(); rs2 = 5'd5; deliver(5'd5, 2'b00, 1);
        #1; chk("kill_stall_pre", 32'(id_stall), 1);
        cycle();
        idle(); rs2 = 5'd5;
        #1; chk("kill_nowrite", 32'(RUwrite), 0);
        cycle();
        idle(); rs2 = 5'd5; RU2 = 32'h0BAD_F00D;
        #1;
        chk("kill_released", 32'(id_stall), 0);
        chk("kill_RU2", id_RU2, 32'h0BAD_F00D);
        cycle();

        idle(); issue(5'd0);
        #1; chk("x0_stall", 32'(id_stall), 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(5'd7);
            #1; chk("sat_fill", 32'(id_stall), 0);
            cycle();
        end
        idle(); issue(5'd7); deliver(5'd7, 2'b00, 0);
        #1; chk("sat_stall", 32'(id_stall), 1);
        cycle();
        idle(); issue(5'd7);
        #1; chk("sat_issue_retire", 32'(id_stall), 0);
        cycle();
        idle(); issue(5'd7);
        #1; chk("sat_still_full", 32'(id_stall), 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); deliver(5'd7, 2'b00, 0);
            cycle();
        end
        idle(); cycle(); idle(); cycle();

        for (int n = 0; n < 2000; n++) rand_cycle();

        idle(); rs1 = 5'd1; rs2 = 5'd2;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_RUwrite", 32'(RUwrite), 0);
        chk("mid_rst_RUdw", RUdw, 0);
        chk("mid_rst_stall", 32'(id_stall), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int n = 0; n < 300; n++) rand_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ru_wb_ctrl.md
# ru_wb_ctrl

Write-side controller for the register unit `ru`. It registers the MEM→WB pipeline stage, selects the write-back value, and drives the `ru` write port (`RUwrite`, `rd`, `RUdw`). It also keeps a per-register pending-write scoreboard that stalls decode on read-after-write hazards. It bypasses `RUdw` onto the decode read operands when the hazard retires in the same cycle.

## Interface

Parameters:
- `XLEN`, 32, data width.
- `CNT_W`, 2, width of each per-register pending counter; at most `2**CNT_W-1` writes in flight per register.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_issue`  in  1  decode hands an instruction to EX this cycle; ignored while `id_stall`=1.
- `id_RUwrite`  in  1  issuing instruction writes a register.
- `id_rd`  in  5  destination of the issuing instruction.
- `rs1`, `rs2`  in  5 each  decode source addresses; also routed to `ru`.
- `RU1`, `RU2`  in  XLEN each  raw read data from `ru`.
- `mem_valid`  in  1  MEM stage holds an instruction.
- `mem_tracked`  in  1  the instruction was counted at issue (`id_RUwrite`=1 and `id_rd`≠0).
- `mem_kill`  in  1  instruction squashed; retire it without writing.
- `mem_rd`  in  5  destination register.
- `mem_RUdataWrSrc`  in  2  write-back source: 00 ALU, 01 data memory, 10 PC+4, 11 reserved (selects ALU).
- `mem_alu_res`, `mem_dm_rd`, `mem_pc_inc`  in  XLEN each  candidate write-back values.
- `RUwrite`  out  1  write enable to `ru`.
- `rd`  out  5  write address to `ru`.
- `RUdw`  out  XLEN  write data to `ru`.
- `id_stall`  out  1  decode must hold.
- `id_RU1`, `id_RU2`  out  XLEN each  read operands after bypass.

## Operation

- WB register: on every rising edge it captures `wb_valid`=`mem_valid`, `wb_tracked`=`mem_valid & mem_tracked`, `wb_kill`, `wb_rd`, and the selected `wb_data`. It never stalls.
- `RUwrite` = `wb_valid & wb_tracked & ~wb_kill` (so `wb_rd`≠0 is guaranteed). `rd`=`wb_rd`, `RUdw`=`wb_data`.
- `retire` = `wb_valid & wb_tracked`, including killed instructions, which release their counter without writing.
- Scoreboard: `cnt[1..31]`, each CNT_W bits. `cnt[0]` is tied to 0 and never counts.
  - `inc` = `id_issue & ~id_stall & id_RUwrite & id_rd≠0`.
  - `dec` = `retire` on `wb_rd`.
  - Same register with both `inc` and `dec` in one cycle: the counter is unchanged.
- Hazard for a source `rsN`≠0:
  - Clear when `cnt[rsN]`=0.
  - Bypassable when `cnt[rsN]`=1 and `RUwrite` & `rd`==`rsN`: `id_RUN`=`RUdw`, no stall.
  - Otherwise it stalls.
  - Source 0: never a hazard, `id_RUN`=`RU_N` (`ru` returns 0).
- Saturation: issue also stalls when `inc` would target a counter at its maximum. No wrap is ever permitted.
- `id_stall` = hazard(rs1) | hazard(rs2) | saturation. It is combinational.

## Timing

- Reset (async assert, sync-released state): all counters 0, `wb_valid`/`wb_tracked`/`wb_kill` 0, `wb_rd` 0, `wb_data` 0. Hence `RUwrite`=0, `rd`=0, `RUdw`=0, `id_stall`=0.
- Reset asserted mid-operation clears everything immediately. In-flight instructions are lost; upstream stages must reset together.
- MEM inputs to `ru` write port: 1 cycle latency. `ru` commits on the edge after `RUwrite` is seen.
- `id_stall` and `id_RU1`/`id_RU2` are combinational from `rs1`/`rs2`, the counters, and the WB register. There is no combinational path from MEM inputs.
- Counter update is visible the cycle after issue or retire.
- An instruction counted at issue must reach WB with `mem_tracked`=1 exactly once, or the scoreboard leaks. The pipeline guarantees this.

## Structure

- Shared package `riscv_pkg`: enum `wb_src_e` (WB_ALU=2'b00, WB_DMEM=2'b01, WB_PC4=2'b10), `XLEN`, register-index width 5.
- One sub-module `ru_scoreboard` (counter array, inc/dec, per-source hazard query). The WB register, source mux and bypass stay in the top.

## Test plan

- Reset: with `rst_n`=0, drive `mem_valid`=1 → `RUwrite`=0, `rd`=0, `RUdw`=0, `id_stall`=0.
- Write-back mux: MEM rd=21, src=01, `mem_dm_rd`=32'hAAAAAA95 → next cycle `RUwrite`=1, `rd`=21, `RUdw`=32'hAAAAAA95. Then src=10, rd=18, `mem_pc_inc`=32'hF565FA95 → `rd`=18, `RUdw`=32'hF565FA95.
- RAW stall: issue rd=21. Next cycle rs1=21 → `id_stall`=1 until the retire cycle. In that cycle `id_stall`=0 and `id_RU1`=`RUdw`. The following cycle `id_RU1`=`RU1`.
- Kill: issue rd=5, deliver it with `mem_kill`=1 → `RUwrite` stays 0, `cnt[5]` returns to 0, and rs2=5 no longer stalls.
- x0 and saturation: issue rd=0 → no stall on rs1=0. Issue rd=7 three times without retire → the fourth issue of rd=7 gets `id_stall`=1. Simultaneous issue+retire of rd=7 leaves the count at 3.
